dcache_ctrl: RTL and testbench

//  MEM-stage data cache, direct-mapped and write-back. Sits directly downstream of the EX/MEM

---
 rtl/dcache_ctrl.sv | 125 ++++++++++++
 tb/tb_dcache_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back MEM-stage data cache with a blocking miss FSM.
// Whole lines move to and from off-chip memory over a req/ack handshake.
module dcache_ctrl #(
  parameter int LINES  = 16,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 5 - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINE_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0]  lat_idx_q;
  logic [TAG_W-1:0]  lat_tag_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [2:0]        req_word;
  logic              hit;
  logic              store_hit;
  logic              unused_addr_bits;

  assign req_idx          = cpu_addr_i[5+IDX_W-1:5];
  assign req_tag          = cpu_addr_i[ADDR_W-1:5+IDX_W];
  assign req_word         = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit = cpu_req_i & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);

  // Stores merge only from IDLE so a refill's DONE cycle cannot write twice.
  assign store_hit = hit & cpu_we_i & (state_q == S_IDLE);

  assign cpu_data_o = (hit & ~cpu_we_i) ? data_mem[req_idx][{req_word, 5'b0} +: 32] : 32'h0;

  assign cpu_stall_o = rst_i & ((cpu_req_i & ~hit & (state_q == S_IDLE)) | (state_q != S_IDLE));

  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_i && !hit) begin
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_mem[lat_idx_q], lat_idx_q, 5'b0};
        mem_data_o = data_mem[lat_idx_q];
        if (mem_ack_i) state_d = S_FILL;
      end
      S_FILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {lat_tag_q, lat_idx_q, 5'b0};
        if (mem_ack_i) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      valid_q   <= '0;
      dirty_q   <= '0;
      lat_idx_q <= '0;
      lat_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && state_d != S_IDLE) begin
        lat_idx_q <= req_idx;
        lat_tag_q <= req_tag;
      end
      if (store_hit) dirty_q[req_idx] <= 1'b1;
      if (state_q == S_WB && mem_ack_i) dirty_q[lat_idx_q] <= 1'b0;
      if (state_q == S_FILL && mem_ack_i) begin
        valid_q[lat_idx_q] <= 1'b1;
        dirty_q[lat_idx_q] <= 1'b0;
      end
    end
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clk_i) begin
    if (store_hit) begin
      data_mem[req_idx][{req_word, 5'b0} +: 32] <= cpu_data_i;
    end
    if (state_q == S_FILL && mem_ack_i) begin
      data_mem[lat_idx_q] <= mem_data_i;
      tag_mem[lat_idx_q]  <= lat_tag_q;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a latency-programmable line memory model,
// hand-sequenced miss scenarios and a table of single-cycle hit vectors.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  logic         model_ack = 1'b0;
  logic         manual_ack = 1'b0;
  int           lat = 3;
  int           cnt = 0;

  logic [31:0]  log_addr [16];
  logic         log_we   [16];
  logic [255:0] log_data [16];
  int           log_n = 0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  // Memory contents: every word encodes its line address and word number.
  function automatic logic [31:0] gw(input logic [31:0] line_addr, input int w);
    return {8'hA5, line_addr[15:0], 8'(w)};
  endfunction

  function automatic logic [255:0] gen_line(input logic [31:0] line_addr);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = gw(line_addr, i);
    return l;
  endfunction

  assign mem_data_i = gen_line(mem_addr_o);
  assign mem_ack_i  = model_ack | manual_ack;

  // Acks on the lat-th cycle that req has been high in the current phase.
  always @(negedge clk_i) begin
    logic was;
    was = model_ack;
    model_ack = 1'b0;
    if (was || !mem_req_o) cnt = 0;
    if (mem_req_o) begin
      cnt++;
      if (cnt == lat) begin
        model_ack = 1'b1;
        if (log_n < 16) begin
          log_addr[log_n] = mem_addr_o;
          log_we[log_n]   = mem_we_o;
          log_data[log_n] = mem_data_o;
        end
        log_n++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    cpu_req_i  = req;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wdata;
    #1;
  endtask

  task automatic run_stall(input string name, input int exp_cycles);
    int cyc = 0;
    while (cpu_stall_o === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    check(name, 32'(cyc), 32'(exp_cycles));
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset with a pending request: all outputs must stay quiet.
    rst_i = 1'b0;
    apply(1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    tick();
    check("rst_mem_req",  32'(mem_req_o),   32'h0);
    check("rst_mem_we",   32'(mem_we_o),    32'h0);
    check("rst_mem_addr", mem_addr_o,       32'h0);
    check("rst_mem_data", 32'(|mem_data_o), 32'h0);
    check("rst_stall",    32'(cpu_stall_o), 32'h0);
    check("rst_cpu_data", cpu_data_o,       32'h0);
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b1;
    tick();
    check("idle_stall", 32'(cpu_stall_o), 32'h0);

    // 1: clean load miss, latency 3.
    lat = 3;
    base = log_n;
    apply(1'b1, 1'b0, 32'h40, 32'h0);
    run_stall("t1_stall_cycles", 5);
    check("t1_txn_count", 32'(log_n - base), 32'd1);
    check("t1_fill_we",   32'(log_we[base]), 32'h0);
    check("t1_fill_addr", log_addr[base],    32'h40);
    check("t1_load_data", cpu_data_o,        gw(32'h40, 0));

    // 2: store hit then same-address load hit.
    apply(1'b1, 1'b1, 32'h44, 32'hDEADBEEF);
    check("t2_store_stall", 32'(cpu_stall_o), 32'h0);
    check("t2_store_data",  cpu_data_o,       32'h0);
    tick();
    apply(1'b1, 1'b0, 32'h44, 32'h0);
    check("t2_load_stall", 32'(cpu_stall_o), 32'h0);
    check("t2_load_data",  cpu_data_o,       32'hDEADBEEF);

    // 3: conflict miss on dirty idx 2 -> write-back then fill, latency 2.
    lat = 2;
    base = log_n;
    apply(1'b1, 1'b0, 32'h240, 32'h0);
    run_stall("t3_stall_cycles", 6);
    check("t3_txn_count", 32'(log_n - base),          32'd2);
    check("t3_wb_we",     32'(log_we[base]),          32'h1);
    check("t3_wb_addr",   log_addr[base],             32'h40);
    check("t3_wb_word1",  log_data[base][63:32],      32'hDEADBEEF);
    check("t3_wb_word0",  log_data[base][31:0],       gw(32'h40, 0));
    check("t3_fill_we",   32'(log_we[base+1]),        32'h0);
    check("t3_fill_addr", log_addr[base+1],           32'h240);
    check("t3_load_data", cpu_data_o,                 gw(32'h240, 0));

    // 4: store miss to clean line, latency 1 -> fill only, merge after DONE.
    lat = 1;
    base = log_n;
    apply(1'b1, 1'b1, 32'h80, 32'h12345678);
    run_stall("t4_stall_cycles", 3);
    check("t4_txn_count", 32'(log_n - base), 32'd1);
    check("t4_fill_we",   32'(log_we[base]), 32'h0);
    check("t4_fill_addr", log_addr[base],    32'h80);
    tick();
    apply(1'b1, 1'b0, 32'h80, 32'h0);
    check("t4_rd_stall", 32'(cpu_stall_o), 32'h0);
    check("t4_rd_word0", cpu_data_o,       32'h12345678);
    apply(1'b1, 1'b0, 32'h84, 32'h0);
    check("t4_rd_word1", cpu_data_o,       gw(32'h80, 1));
    // Evicting idx 4 proves the merged store left the line dirty.
    base = log_n;
    apply(1'b1, 1'b0, 32'h280, 32'h0);
    run_stall("t4_evict_stall", 4);
    check("t4_evict_count", 32'(log_n - base),     32'd2);
    check("t4_evict_we",    32'(log_we[base]),     32'h1);
    check("t4_evict_addr",  log_addr[base],        32'h80);
    check("t4_evict_word0", log_data[base][31:0],  32'h12345678);
    check("t4_refill_addr", log_addr[base+1],      32'h280);

    // Table of single-cycle accesses to resident lines (idx 2 = 0x240, idx 4 = 0x280).
    vecs[0] = '{1'b1, 1'b0, 32'h240, 32'h0,        1'b0, gw(32'h240, 0), "v_ld240"};
    vecs[1] = '{1'b1, 1'b0, 32'h25C, 32'h0,        1'b0, gw(32'h240, 7), "v_ld25c"};
    vecs[2] = '{1'b1, 1'b0, 32'h243, 32'h0,        1'b0, gw(32'h240, 0), "v_ld243_lowbits"};
    vecs[3] = '{1'b1, 1'b1, 32'h248, 32'hCAFEF00D, 1'b0, 32'h0,          "v_st248"};
    vecs[4] = '{1'b1, 1'b0, 32'h248, 32'h0,        1'b0, 32'hCAFEF00D,   "v_ld248"};
    vecs[5] = '{1'b0, 1'b0, 32'h248, 32'h0,        1'b0, 32'h0,          "v_noreq"};
    vecs[6] = '{1'b1, 1'b0, 32'h284, 32'h0,        1'b0, gw(32'h280, 1), "v_ld284"};
    vecs[7] = '{1'b1, 1'b1, 32'h29C, 32'h0BADF00D, 1'b0, 32'h0,          "v_st29c"};
    vecs[8] = '{1'b1, 1'b0, 32'h29C, 32'h0,        1'b0, 32'h0BADF00D,   "v_ld29c"};
    vecs[9] = '{1'b1, 1'b0, 32'h244, 32'h0,        1'b0, gw(32'h240, 1), "v_ld244"};
    for (int i = 0; i < 10; i++) begin
      apply(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check({vecs[i].name, "_stall"}, 32'(cpu_stall_o), 32'(vecs[i].exp_stall));
      check({vecs[i].name, "_data"},  cpu_data_o,       vecs[i].exp_data);
      tick();
    end

    // 6: stray ack while idle must be ignored.
    apply(1'b0, 1'b0, 32'h0, 32'h0);
    manual_ack = 1'b1;
    tick();
    manual_ack = 1'b0;
    check("t6_stall",   32'(cpu_stall_o), 32'h0);
    check("t6_mem_req", 32'(mem_req_o),   32'h0);
    tick();
    check("t6_mem_req_later", 32'(mem_req_o), 32'h0);
    apply(1'b1, 1'b0, 32'h248, 32'h0);
    check("t6_hit_stall", 32'(cpu_stall_o), 32'h0);
    check("t6_hit_data",  cpu_data_o,       32'hCAFEF00D);

    // 5: reset during FILL aborts at once and invalidates the cache.
    lat = 5;
    apply(1'b1, 1'b0, 32'hA0, 32'h0);
    tick();
    tick();
    check("t5_req_before_rst", 32'(mem_req_o), 32'h1);
    rst_i = 1'b0;
    #1;
    check("t5_rst_mem_req", 32'(mem_req_o),   32'h0);
    check("t5_rst_stall",   32'(cpu_stall_o), 32'h0);
    check("t5_rst_data",    cpu_data_o,       32'h0);
    tick();
    rst_i = 1'b1;
    #1;
    check("t5_remiss_stall", 32'(cpu_stall_o), 32'h1);
    run_stall("t5_refill_stall", 7);
    check("t5_refill_data", cpu_data_o, gw(32'hA0, 0));
    apply(1'b1, 1'b0, 32'h248, 32'h0);
    check("t5_lost_hit_stall", 32'(cpu_stall_o), 32'h1);
    run_stall("t5_lost_hit_cycles", 7);
    check("t5_lost_hit_data", cpu_data_o, gw(32'h240, 2));

    apply(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
